s2mm_packet_arbiter: RTL and testbench

Return-path counterpart to the MM2S packet filter. It drains NUM_FIFOS first-word-fall-through (FWFT) accelerator result FIFOs and merges them into one AXI Stream toward the MCDMA S2MM slave port. Each transfer is a fixed-length packet: tdest carries the source FIFO index and tlast marks the final word. A channel holds the grant for a whole packet; grants rotate round-robin at packet boundaries.

---
 rtl/s2mm_packet_arbiter.sv | 165 ++++++++++++++++
 tb/tb_s2mm_packet_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s2mm_packet_arbiter.sv
// s2mm_packet_arbiter
//   Drains NUM_FIFOS first-word-fall-through result FIFOs into one AXI Stream
//   toward the DMA S2MM port. Each packet is PACKET_WORDS words taken from a
//   single FIFO. tdest carries the source index and tlast marks the final word.
//   The grant is held for the whole packet and rotates round-robin at packet
//   boundaries.
//
// Ports
//   clk, rst        single clock, asynchronous active-high reset
//   enable          gates the start of new packets (a packet in flight completes)
//   fifo_empty      per-FIFO empty flags
//   fifo_rden       per-FIFO pop strobes (combinational, at most one bit high)
//   fifo_data       packed FWFT head words, FIFO i at [i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH]
//   M_AXIS_*        registered AXI Stream master (tdata/tdest/tlast/tvalid, tready in)
//   busy            high while a packet is granted or a word is still held
//
// FSM
//   state   | meaning
//   IDLE    | pick the next non-empty FIFO after last_grant (one cycle)
//   XFER    | pop words from FIFO sel until PACKET_WORDS have been taken

module s2mm_packet_arbiter #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int AXIS_DEST_WIDTH = 4,
  parameter int NUM_FIFOS       = 2,
  parameter int PACKET_WORDS    = 256
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic [NUM_FIFOS-1:0]                 fifo_empty,
  output logic [NUM_FIFOS-1:0]                 fifo_rden,
  input  logic [NUM_FIFOS*FIFO_DATA_WIDTH-1:0] fifo_data,
  output logic [AXIS_DATA_WIDTH-1:0]           M_AXIS_tdata,
  output logic [AXIS_DEST_WIDTH-1:0]           M_AXIS_tdest,
  output logic                                 M_AXIS_tlast,
  output logic                                 M_AXIS_tvalid,
  input  logic                                 M_AXIS_tready,
  output logic                                 busy
);

  localparam int SEL_W = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
  localparam int CNT_W = (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PACKET_WORDS - 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_FIFOS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   sel, sel_nxt;
  logic [SEL_W-1:0]   last_grant, last_grant_nxt;
  logic [CNT_W-1:0]   word_cnt, word_cnt_nxt;

  logic [SEL_W-1:0]           grant_idx;
  logic                       grant_any;
  logic                       pop;
  logic                       last_word;
  logic [AXIS_DATA_WIDTH-1:0] head_ext;

  // Round-robin search: candidates last_grant+1, +2, ... wrapping, so the
  // channel served last has the lowest priority.
  always_comb begin
    int cand;
    cand      = 0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= NUM_FIFOS; k++) begin
      cand = (int'(last_grant) + k) % NUM_FIFOS;
      if (!grant_any && !fifo_empty[cand]) begin
        grant_any = 1'b1;
        grant_idx = SEL_W'(cand);
      end
    end
  end

  // A pop needs a word at the selected head and a free (or draining) output
  // register; this is what gives full throughput with tready held high.
  assign pop       = (state == ST_XFER) && !fifo_empty[sel] &&
                     (!M_AXIS_tvalid || M_AXIS_tready);
  assign last_word = (word_cnt == LAST_CNT);

  always_comb begin
    head_ext = '0;
    head_ext[FIFO_DATA_WIDTH-1:0] = fifo_data[int'(sel)*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
  end

  always_comb begin
    fifo_rden = '0;
    if (pop) begin
      fifo_rden[sel] = 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    last_grant_nxt = last_grant;
    word_cnt_nxt   = word_cnt;
    case (state)
      ST_IDLE: begin
        if (enable && grant_any) begin
          sel_nxt      = grant_idx;
          word_cnt_nxt = '0;
          state_nxt    = ST_XFER;
        end
      end
      ST_XFER: begin
        // An empty head simply stalls here; the grant is never dropped early.
        if (pop) begin
          if (last_word) begin
            word_cnt_nxt   = '0;
            last_grant_nxt = sel;
            state_nxt      = ST_IDLE;
          end else begin
            word_cnt_nxt = word_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel        <= '0;
      last_grant <= LAST_IDX;
      word_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      last_grant <= last_grant_nxt;
      word_cnt   <= word_cnt_nxt;
    end
  end

  // Output register: loads on a pop, holds while stalled, empties when the
  // held word is taken and nothing replaces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      M_AXIS_tdata  <= '0;
      M_AXIS_tdest  <= '0;
      M_AXIS_tlast  <= 1'b0;
      M_AXIS_tvalid <= 1'b0;
    end else if (pop) begin
      M_AXIS_tdata  <= head_ext;
      M_AXIS_tdest  <= AXIS_DEST_WIDTH'(sel);
      M_AXIS_tlast  <= last_word;
      M_AXIS_tvalid <= 1'b1;
    end else if (M_AXIS_tvalid && M_AXIS_tready) begin
      M_AXIS_tlast  <= 1'b0;
      M_AXIS_tvalid <= 1'b0;
    end
  end

  assign busy = (state == ST_XFER) || M_AXIS_tvalid;

endmodule

// File: tb/tb_s2mm_packet_arbiter.sv
// Scoreboard bench for s2mm_packet_arbiter (NUM_FIFOS=2, PACKET_WORDS=4).
// The driver loads modelled FIFOs and pushes expected beats; a monitor pops
// and compares on every AXIS handshake and checks hold/pop legality.

module tb_s2mm_packet_arbiter;

  localparam int DW    = 32;
  localparam int FW    = 32;
  localparam int DESTW = 4;
  localparam int NF    = 2;
  localparam int PW    = 4;

  typedef struct {
    logic [DESTW-1:0] dest;
    logic [DW-1:0]    data;
    logic             last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [NF-1:0]     fifo_empty = '1;
  logic [NF-1:0]     fifo_rden;
  logic [NF*FW-1:0]  fifo_data = '0;
  logic [DW-1:0]     M_AXIS_tdata;
  logic [DESTW-1:0]  M_AXIS_tdest;
  logic              M_AXIS_tlast;
  logic              M_AXIS_tvalid;
  logic              M_AXIS_tready = 1'b1;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int tr_mode = 0;

  logic [FW-1:0] src [NF][$];
  int            rd_ptr [NF];
  beat_t         exp_q[$];
  int            exp_rd = 0;
  int            stamps[$];

  s2mm_packet_arbiter #(
    .AXIS_DATA_WIDTH(DW), .FIFO_DATA_WIDTH(FW), .AXIS_DEST_WIDTH(DESTW),
    .NUM_FIFOS(NF), .PACKET_WORDS(PW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_rden(fifo_rden), .fifo_data(fifo_data),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tdest(M_AXIS_tdest),
    .M_AXIS_tlast(M_AXIS_tlast), .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tready(M_AXIS_tready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // FWFT FIFO model: heads presented from the queues, pops applied at the edge.
  initial begin
    logic [NF-1:0] rd_s;
    for (int i = 0; i < NF; i++) rd_ptr[i] = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) for (int i = 0; i < NF; i++) rd_ptr[i] = src[i].size();
      fifo_data = '0;
      for (int i = 0; i < NF; i++) begin
        fifo_empty[i] = (rd_ptr[i] >= src[i].size());
        if (!fifo_empty[i]) fifo_data[i*FW +: FW] = src[i][rd_ptr[i]];
      end
      #1;
      rd_s = fifo_rden;
      @(posedge clk);
      if (!rst)
        for (int i = 0; i < NF; i++)
          if (rd_s[i] && rd_ptr[i] < src[i].size()) rd_ptr[i] = rd_ptr[i] + 1;
    end
  end

  // tready source: 0 = always high, 1 = pattern 1,0,0,1, 2 = random (3/4 high)
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      case (tr_mode)
        1:       M_AXIS_tready = (ph % 4 == 0) || (ph % 4 == 3);
        2:       M_AXIS_tready = ($urandom_range(0, 3) != 0);
        default: M_AXIS_tready = 1'b1;
      endcase
      ph = ph + 1;
    end
  end

  // Monitor
  initial begin
    logic  stall_prev;
    beat_t held;
    beat_t e;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        exp_rd     = exp_q.size();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          vectors = vectors + 1;
          if (!M_AXIS_tvalid || M_AXIS_tdata !== held.data ||
              M_AXIS_tdest !== held.dest || M_AXIS_tlast !== held.last) begin
            miscompares = miscompares + 1;
            $display("FAIL hold_stable: got valid=%b dest=%0d data=%h last=%b, want valid=1 dest=%0d data=%h last=%b",
                     M_AXIS_tvalid, M_AXIS_tdest, M_AXIS_tdata, M_AXIS_tlast, held.dest, held.data, held.last);
          end
        end
        if (fifo_rden != '0) begin
          vectors = vectors + 1;
          if (!$onehot(fifo_rden) || (M_AXIS_tvalid && !M_AXIS_tready) ||
              ((fifo_rden & fifo_empty) != '0)) begin
            miscompares = miscompares + 1;
            $display("FAIL rden_legal: got rden=%b empty=%b valid=%b ready=%b, want one-hot pop of non-empty FIFO with free output",
                     fifo_rden, fifo_empty, M_AXIS_tvalid, M_AXIS_tready);
          end
        end
        if (M_AXIS_tvalid && M_AXIS_tready) begin
          stamps.push_back(cyc);
          vectors = vectors + 1;
          if (exp_rd >= exp_q.size()) begin
            miscompares = miscompares + 1;
            $display("FAIL beat_unexpected: got dest=%0d data=%h last=%b, want no beat",
                     M_AXIS_tdest, M_AXIS_tdata, M_AXIS_tlast);
          end else begin
            e = exp_q[exp_rd];
            exp_rd = exp_rd + 1;
            if (M_AXIS_tdest !== e.dest || M_AXIS_tdata !== e.data || M_AXIS_tlast !== e.last) begin
              miscompares = miscompares + 1;
              $display("FAIL beat %0d: got dest=%0d data=%h last=%b, want dest=%0d data=%h last=%b",
                       exp_rd - 1, M_AXIS_tdest, M_AXIS_tdata, M_AXIS_tlast, e.dest, e.data, e.last);
            end
          end
        end
        stall_prev = M_AXIS_tvalid && !M_AXIS_tready;
        held.dest  = M_AXIS_tdest;
        held.data  = M_AXIS_tdata;
        held.last  = M_AXIS_tlast;
      end
    end
  end

  task automatic push_src(int i, logic [FW-1:0] base, int n);
    for (int k = 0; k < n; k++) src[i].push_back(base + FW'(k));
  endtask

  task automatic expect_pkt(int dest, logic [FW-1:0] base);
    beat_t b;
    for (int k = 0; k < PW; k++) begin
      b.dest = DESTW'(dest);
      b.data = DW'(base + FW'(k));
      b.last = (k == PW - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    tr_mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(string name, int limit);
    int n;
    n = 0;
    while (exp_rd < exp_q.size() && n < limit) begin
      @(negedge clk);
      n++;
    end
    vectors = vectors + 1;
    if (exp_rd < exp_q.size()) begin
      miscompares = miscompares + 1;
      $display("FAIL %s drain: got %0d beats outstanding after %0d cycles, want 0", name, exp_q.size() - exp_rd, limit);
    end
  endtask

  task automatic wait_beats(string name, int target, int limit);
    int n;
    n = 0;
    while (stamps.size() < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    vectors = vectors + 1;
    if (stamps.size() < target) begin
      miscompares = miscompares + 1;
      $display("FAIL %s beats: got %0d, want %0d", name, stamps.size(), target);
    end
  endtask

  task automatic random_run(int iter);
    int            rem [NF];
    logic [FW-1:0] mq [NF][$];
    logic [FW-1:0] w;
    beat_t         b;
    int            last, idx;
    bit            any;
    do_reset();
    tr_mode = 2;
    for (int i = 0; i < NF; i++) begin
      rem[i] = $urandom_range(0, 3);
      for (int k = 0; k < rem[i] * PW; k++) begin
        w = $urandom;
        mq[i].push_back(w);
      end
    end
    // Reference: all data present up front, so packets simply alternate
    // round-robin over FIFOs that still hold whole packets, starting after FIFO NF-1.
    last = NF - 1;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int k = 1; k <= NF; k++) begin
        idx = (last + k) % NF;
        if (!any && rem[idx] > 0) begin
          any = 1'b1;
          for (int j = 0; j < PW; j++) begin
            b.dest = DESTW'(idx);
            b.data = DW'(mq[idx].pop_front());
            b.last = (j == PW - 1);
            exp_q.push_back(b);
            src[idx].push_back(b.data);
          end
          rem[idx]--;
          last = idx;
        end
      end
    end
    enable = 1'b1;
    wait_drain($sformatf("random%0d", iter), 400);
  endtask

  initial begin
    int b0;
    #1;
    vectors = vectors + 1;
    if (M_AXIS_tvalid !== 1'b0 || M_AXIS_tlast !== 1'b0 || M_AXIS_tdata !== '0 ||
        M_AXIS_tdest !== '0 || fifo_rden !== '0 || busy !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL reset_state: got valid=%b last=%b data=%h dest=%0d rden=%b busy=%b, want all 0",
               M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata, M_AXIS_tdest, fifo_rden, busy);
    end

    // Single source: two packets with one idle bubble between them.
    do_reset();
    b0 = stamps.size();
    expect_pkt(0, 32'h10);
    expect_pkt(0, 32'h14);
    push_src(0, 32'h10, 8);
    enable = 1'b1;
    wait_drain("single", 60);
    if (stamps.size() >= b0 + 5) begin
      vectors = vectors + 1;
      if (stamps[b0+1] - stamps[b0] != 1 || stamps[b0+4] - stamps[b0+3] != 2) begin
        miscompares = miscompares + 1;
        $display("FAIL bubble: got gaps %0d and %0d, want 1 and 2",
                 stamps[b0+1] - stamps[b0], stamps[b0+4] - stamps[b0+3]);
      end
    end

    // Round-robin between two loaded FIFOs.
    do_reset();
    expect_pkt(0, 32'h20); expect_pkt(1, 32'h30);
    expect_pkt(0, 32'h24); expect_pkt(1, 32'h34);
    push_src(0, 32'h20, 8);
    push_src(1, 32'h30, 8);
    enable = 1'b1;
    wait_drain("round_robin", 80);

    // Backpressure pattern 1,0,0,1.
    do_reset();
    tr_mode = 1;
    expect_pkt(0, 32'h40); expect_pkt(1, 32'h50);
    expect_pkt(0, 32'h44); expect_pkt(1, 32'h54);
    push_src(0, 32'h40, 8);
    push_src(1, 32'h50, 8);
    enable = 1'b1;
    wait_drain("backpressure", 200);

    // Mid-packet starvation of FIFO1 while FIFO0 waits.
    do_reset();
    enable = 1'b1;
    expect_pkt(0, 32'h60);
    push_src(0, 32'h60, 4);
    wait_drain("starve_pre", 40);
    expect_pkt(1, 32'h70);
    expect_pkt(0, 32'h64);
    push_src(1, 32'h70, 2);
    push_src(0, 32'h64, 4);
    repeat (20) @(negedge clk);
    #1;
    vectors = vectors + 1;
    if (M_AXIS_tvalid !== 1'b0 || busy !== 1'b1 || (src[0].size() - rd_ptr[0]) != 4 ||
        exp_rd != exp_q.size() - 6) begin
      miscompares = miscompares + 1;
      $display("FAIL starve_hold: got valid=%b busy=%b fifo0_left=%0d beats_left=%0d, want valid=0 busy=1 fifo0_left=4 beats_left=6",
               M_AXIS_tvalid, busy, src[0].size() - rd_ptr[0], exp_q.size() - exp_rd);
    end
    push_src(1, 32'h72, 2);
    wait_drain("starve", 60);

    // Enable gating.
    do_reset();
    push_src(0, 32'hA0, 8);
    repeat (6) begin
      @(negedge clk);
      #1;
      vectors = vectors + 1;
      if (M_AXIS_tvalid !== 1'b0 || busy !== 1'b0 || fifo_rden !== '0) begin
        miscompares = miscompares + 1;
        $display("FAIL enable_off: got valid=%b busy=%b rden=%b, want 0 0 00", M_AXIS_tvalid, busy, fifo_rden);
      end
    end
    b0 = stamps.size();
    expect_pkt(0, 32'hA0);
    @(negedge clk);
    enable = 1'b1;
    wait_beats("enable_on", b0 + 1, 20);
    enable = 1'b0;
    wait_drain("enable_drop", 40);
    repeat (10) @(negedge clk);
    #1;
    vectors = vectors + 1;
    if (M_AXIS_tvalid !== 1'b0 || busy !== 1'b0 || (src[0].size() - rd_ptr[0]) != 4) begin
      miscompares = miscompares + 1;
      $display("FAIL enable_drop_idle: got valid=%b busy=%b fifo0_left=%0d, want 0 0 4",
               M_AXIS_tvalid, busy, src[0].size() - rd_ptr[0]);
    end

    // Reset mid-packet of FIFO1 after FIFO0 was last served.
    do_reset();
    enable = 1'b1;
    expect_pkt(0, 32'h80);
    push_src(0, 32'h80, 4);
    wait_drain("rst_pre", 40);
    b0 = stamps.size();
    expect_pkt(1, 32'h84);
    push_src(1, 32'h84, 4);
    wait_beats("rst_mid", b0 + 2, 30);
    rst = 1'b1;
    #1;
    vectors = vectors + 1;
    if (M_AXIS_tvalid !== 1'b0 || M_AXIS_tlast !== 1'b0 || fifo_rden !== '0) begin
      miscompares = miscompares + 1;
      $display("FAIL rst_async: got valid=%b last=%b rden=%b, want 0 0 00", M_AXIS_tvalid, M_AXIS_tlast, fifo_rden);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    expect_pkt(0, 32'h90);
    expect_pkt(1, 32'h94);
    push_src(0, 32'h90, 4);
    push_src(1, 32'h94, 4);
    wait_drain("rst_after", 60);

    for (int it = 0; it < 4; it++) random_run(it);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
